// File: rtl/load_hazard_scheduler.sv
// Scoreboard for in-flight loads: tracks destination registers of outstanding loads,
// raises RAW stalls in decode, blocks WAW issues and pairs in-order responses with their rd.
module load_hazard_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic [INDEX_WIDTH-1:0]         issue_rd,
    output logic                           issue_ready,
    input  logic [INDEX_WIDTH-1:0]         rs1_index,
    input  logic [INDEX_WIDTH-1:0]         rs2_index,
    input  logic                           rs1_used,
    input  logic                           rs2_used,
    output logic                           hazard_stall,
    input  logic                           resp_valid,
    output logic [INDEX_WIDTH-1:0]         resp_rd,
    output logic                           resp_write_enable,
    input  logic                           flush,
    output logic                           protocol_error,
    output logic [(2**INDEX_WIDTH)-1:0]    busy_vector,
    output logic [$clog2(QUEUE_DEPTH):0]   outstanding_count,
    output logic [1:0]                     state
);

    localparam int PW   = $clog2(QUEUE_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** INDEX_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [NREG-1:0]        busy_q, busy_d;
    logic                   perr_q, perr_d;
    logic [INDEX_WIDTH-1:0] fifo_q [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_d [QUEUE_DEPTH];

    logic                   issue_acc;
    logic                   resp_deq;
    logic [INDEX_WIDTH-1:0] head;

    assign head = fifo_q[rd_ptr_q];

    // A nonzero rd that is already pending is a WAW hazard and must wait for its response.
    assign issue_ready = (state_q != DRAIN) && (count_q < DEPTH_C) &&
                         !((issue_rd != '0) && busy_q[issue_rd]);
    assign issue_acc   = issue_valid && issue_ready;
    assign resp_deq    = resp_valid && (count_q != '0);

    assign hazard_stall = (rs1_used && (rs1_index != '0) && busy_q[rs1_index]) ||
                          (rs2_used && (rs2_index != '0) && busy_q[rs2_index]);

    assign resp_rd           = head;
    assign resp_write_enable = resp_deq && (state_q != DRAIN) && (head != '0);
    assign protocol_error    = perr_q;
    assign busy_vector       = busy_q;
    assign outstanding_count = count_q;
    assign state             = state_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = busy_q;
        fifo_d   = fifo_q;
        perr_d   = resp_valid && (count_q == '0);

        if (resp_deq) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            busy_d[head] = 1'b0;
        end
        if (issue_acc) begin
            fifo_d[wr_ptr_q] = issue_rd;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        case ({issue_acc, resp_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flush decisions look at the occupancy left after this cycle's issue and response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_acc) begin
                    state_d = flush ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            perr_q   <= perr_d;
        end
    end

    // Queue payload is only read while count is nonzero, so it needs no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
